// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared sizing helpers and types for the 2-read/1-write register bank
package reg_bank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_word_t;

    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/dest_decoder.sv
// rtl/dest_decoder.sv - one-hot register index decoder, all-zero when disabled
module dest_decoder
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                        en,
    input  logic [ADDR_W-1:0]           addr,
    output logic [depth_of(ADDR_W)-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_2r1w.sv
// rtl/reg_bank_2r1w.sv - DEPTH x DATA_W register bank, registered 2R/1W with bypass and busy scoreboard
module reg_bank_2r1w
    import reg_bank_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr_a,
    input  logic [ADDR_W-1:0]           rd_addr_b,
    output logic [DATA_W-1:0]           rd_data_a,
    output logic [DATA_W-1:0]           rd_data_b,
    output logic                        rd_valid,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic                        hazard_a,
    output logic                        hazard_b,
    output logic [depth_of(ADDR_W)-1:0] busy_vec
);

    localparam int DEPTH = depth_of(ADDR_W);

    // Bit 0 of the scoreboard is forced clear when R0 is hardwired to zero.
    localparam logic [DEPTH-1:0] KEEP_MASK =
        (ZERO_R0 != 0) ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

    logic [DEPTH-1:0]  wr_onehot;
    logic [DEPTH-1:0]  rsv_onehot;
    logic [DEPTH-1:0]  busy_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;

    dest_decoder #(.ADDR_W(ADDR_W)) u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    dest_decoder #(.ADDR_W(ADDR_W)) u_rsv_dec (
        .en     (rsv_en),
        .addr   (rsv_addr),
        .onehot (rsv_onehot)
    );

    // Flop array rather than a RAM macro so every register clears on reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_R0 != 0 && i == 0) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_flop
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[i] <= '0;
                end else if (wr_onehot[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_next_a = mem[rd_addr_a];
        if (wr_en && wr_addr == rd_addr_a) begin
            rd_next_a = wr_data;
        end
        if (ZERO_R0 != 0 && rd_addr_a == '0) begin
            rd_next_a = '0;
        end

        rd_next_b = mem[rd_addr_b];
        if (wr_en && wr_addr == rd_addr_b) begin
            rd_next_b = wr_data;
        end
        if (ZERO_R0 != 0 && rd_addr_b == '0) begin
            rd_next_b = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_a <= rd_next_a;
                rd_data_b <= rd_next_b;
            end
        end
    end

    // Set is applied after clear so a same-cycle reserve of the written register wins.
    always_comb begin
        busy_next = ((busy_vec & ~wr_onehot) | rsv_onehot) & KEEP_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    // The write-back bypass covers the operand, so an in-flight write masks the hazard.
    always_comb begin
        hazard_a = busy_vec[rd_addr_a] & ~(wr_en & (wr_addr == rd_addr_a));
        hazard_b = busy_vec[rd_addr_b] & ~(wr_en & (wr_addr == rd_addr_b));
    end

endmodule
